// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues ROM reads, and buffers
// {pc, instr} pairs for decode through a 2-entry valid/ready FIFO.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  output logic        rom_en,
  input  logic [31:0] rom_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam logic [31:0] START_PC = RESET_PC & ~32'h3;
  localparam logic [2:0]  CREDITS  = 3'(BUF_DEPTH);

  logic        go;
  logic        inflight;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [1:0]  count;
  logic [31:0] head_pc, head_instr;
  logic [31:0] tail_pc, tail_instr;

  logic        pop;
  logic        flush;
  logic        wr;
  logic        issue;
  logic [2:0]  credit_used;
  logic [1:0]  wr_slot;
  logic [31:0] issue_pc;

  assign out_valid = (count != 2'd0);
  assign out_pc    = head_pc;
  assign out_instr = head_instr;

  assign pop   = out_valid & out_ready;
  assign flush = go & redirect_valid;
  // A redirect discards the response returning this cycle.
  assign wr    = inflight & ~redirect_valid;

  // Buffered entries plus the read in flight must leave room for one more.
  assign credit_used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue       = go & ~redirect_valid & (credit_used < CREDITS);

  assign issue_pc = redirect_valid ? (redirect_pc & ~32'h3) : fetch_pc;
  assign rom_en   = issue | flush;
  assign rom_addr = issue_pc >> 2;

  assign wr_slot = count - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go         <= 1'b0;
      inflight   <= 1'b0;
      fetch_pc   <= START_PC;
      req_pc     <= 32'h0;
      count      <= 2'd0;
      head_pc    <= 32'h0;
      head_instr <= 32'h0;
      tail_pc    <= 32'h0;
      tail_instr <= 32'h0;
    end else begin
      go <= 1'b1;

      if (rom_en) begin
        req_pc   <= issue_pc;
        inflight <= 1'b1;
        fetch_pc <= issue_pc + 32'd4;
      end else begin
        inflight <= 1'b0;
      end

      if (flush) begin
        count <= 2'd0;
      end else begin
        if (pop && count == 2'd2) begin
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
        end
        if (wr) begin
          if (wr_slot == 2'd0) begin
            head_pc    <= req_pc;
            head_instr <= rom_dout;
          end else begin
            tail_pc    <= req_pc;
            tail_instr <= rom_dout;
          end
        end
        count <= count - {1'b0, pop} + {1'b0, wr};
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: identity ROM, a queue-based reference of issued
// fetches, directed scenarios with literal expectations, then random traffic.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] rom_addr;
  logic        rom_en;
  logic [31:0] rom_dout = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  instr_fetch #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_en         (rom_en),
    .rom_dout       (rom_dout),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // ROM word i holds value i, registered one cycle.
  always @(posedge clk) if (rom_en) rom_dout <= rom_addr;

  typedef struct {
    logic [31:0] pc;
    int          t;
  } item_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  item_t       q[$];
  bit          go_m;
  logic [31:0] fetch_m;
  logic [31:0] last_pc;
  logic [31:0] last_instr;
  bit          e_pop;
  bit          e_en;
  logic [31:0] e_issue;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    go_m       = 1'b0;
    fetch_m    = RPC & ~32'h3;
    last_pc    = 32'h0;
    last_instr = 32'h0;
  endtask

  // Every fetch issued in cycle t is presentable from cycle t+2 until popped
  // or flushed; issues are allowed while fewer than two remain outstanding.
  task automatic compare();
    bit          ev;
    logic [31:0] ipc;
    ev  = (q.size() > 0) && (q[0].t <= cyc - 2);
    ipc = redirect_valid ? (redirect_pc & ~32'h3) : fetch_m;
    if (ev) begin
      last_pc    = q[0].pc;
      last_instr = q[0].pc >> 2;
    end
    e_pop   = ev & out_ready;
    e_en    = go_m & (redirect_valid | ((q.size() - int'(e_pop)) < 2));
    e_issue = ipc;
    check("out_valid", out_valid, ev);
    check("rom_en", rom_en, e_en);
    check("rom_addr", rom_addr, ipc >> 2);
    check("out_pc", out_pc, last_pc);
    check("out_instr", out_instr, last_instr);
  endtask

  task automatic drive(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    compare();
  endtask

  task automatic tick();
    if (go_m && redirect_valid) q.delete();
    else if (e_pop) void'(q.pop_front());
    if (e_en) begin
      q.push_back('{e_issue, cyc});
      fetch_m = e_issue + 32'd4;
    end
    go_m = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #1;
    check("rst_rom_en", rom_en, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_rom_addr", rom_addr, 32'h40);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic free_run_start();
    drive(0, 0, 1); check("k0_rom_en", rom_en, 1'b0); tick();
    drive(0, 0, 1); check("k1_rom_en", rom_en, 1'b1); check("k1_rom_addr", rom_addr, 32'h40); tick();
    drive(0, 0, 1); check("k2_out_valid", out_valid, 1'b0); check("k2_rom_addr", rom_addr, 32'h41); tick();
    drive(0, 0, 1); check("k3_out_valid", out_valid, 1'b1);
    check("k3_out_pc", out_pc, 32'h100); check("k3_out_instr", out_instr, 32'h40); tick();
    drive(0, 0, 1); check("k4_out_pc", out_pc, 32'h104); check("k4_out_instr", out_instr, 32'h41); tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1); check("stream_valid", out_valid, 1'b1); tick();
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    free_run_start();

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0);
      check("stall_rom_en", rom_en, 1'b0);
      check("stall_valid", out_valid, 1'b1);
      tick();
    end
    drive(0, 0, 1); check("resume_rom_en", rom_en, 1'b1); tick();
    repeat (4) begin drive(0, 0, 1); tick(); end

    // Redirect while streaming
    drive(1, 32'h40, 1);
    check("redir_rom_addr", rom_addr, 32'h10); check("redir_rom_en", rom_en, 1'b1); tick();
    drive(0, 0, 1); check("redir_next_valid", out_valid, 1'b0); tick();
    drive(0, 0, 1); check("redir_out_pc", out_pc, 32'h40); check("redir_out_valid", out_valid, 1'b1); tick();
    repeat (3) begin drive(0, 0, 1); tick(); end

    // Redirect colliding with pop on a full buffer, misaligned target
    repeat (3) begin drive(0, 0, 0); tick(); end
    drive(1, 32'h43, 1); check("coll_rom_addr", rom_addr, 32'h10); tick();
    drive(0, 0, 1); check("coll_next_valid", out_valid, 1'b0); tick();
    drive(0, 0, 1); check("coll_out_pc", out_pc, 32'h40); check("coll_out_instr", out_instr, 32'h10); tick();
    drive(0, 0, 1); check("coll_out_pc2", out_pc, 32'h44); tick();

    // Reset mid-run with a full buffer
    drive(0, 0, 0); tick();
    do_reset();
    free_run_start();

    // PC wrap
    drive(1, 32'hFFFF_FFF8, 1); check("wrap_addr0", rom_addr, 32'h3FFF_FFFE); tick();
    drive(0, 0, 1); check("wrap_addr1", rom_addr, 32'h3FFF_FFFF); check("wrap_en1", rom_en, 1'b1); tick();
    drive(0, 0, 1); check("wrap_addr2", rom_addr, 32'h0); check("wrap_pc0", out_pc, 32'hFFFF_FFF8); tick();
    drive(0, 0, 1); check("wrap_pc1", out_pc, 32'hFFFF_FFFC); tick();
    drive(0, 0, 1); check("wrap_pc2", out_pc, 32'h0); check("wrap_instr2", out_instr, 32'h0); tick();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 7);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
